// File: rtl/botao_pkg.sv
// -----------------------------------------------------------------------------
// botao_pkg
// Shared types and default constants for the pushbutton classifier.
//   estado_t          : classifier FSM state (OCIOSO, PRESSIONADO, LONGO_EMITIDO)
//   DEBOUNCE_PADRAO   : default debounce length, 10 ms at 25 MHz
//   LONGO_PADRAO      : default long-press threshold, 1 s at 25 MHz
//   REPETICAO_PADRAO  : default interval between repeated long pulses, 250 ms
// -----------------------------------------------------------------------------
package botao_pkg;

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        PRESSIONADO   = 2'd1,
        LONGO_EMITIDO = 2'd2
    } estado_t;

    localparam int unsigned DEBOUNCE_PADRAO  = 250000;
    localparam int unsigned LONGO_PADRAO     = 25000000;
    localparam int unsigned REPETICAO_PADRAO = 6250000;

endpackage

// File: rtl/debounce_nivel.sv
// -----------------------------------------------------------------------------
// debounce_nivel
// Two-flop synchroniser, polarity normalisation and level debouncer for one
// raw pushbutton pin.
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   b_in       in   raw asynchronous button pin
//   b_estavel  out  debounced level, 1 = pressed (registered)
//   estavel_d  out  value b_estavel takes at the next clock edge, so a
//                   downstream registered stage can react in the same cycle
//                   the debounced level changes
// -----------------------------------------------------------------------------
module debounce_nivel
    import botao_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_PADRAO,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic b_in,
    output logic b_estavel,
    output logic estavel_d
);

    localparam int unsigned          CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_MAX     = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Released level of the raw pin; the synchroniser starts there so reset
    // never looks like a press.
    localparam logic                 NIVEL_SOLTO = ACTIVE_LOW;

    logic             sinc1_q;
    logic             sinc2_q;
    logic             s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             estavel_q;

    // Counter runs only while the synchronised level disagrees with the
    // accepted one; any agreement restarts the qualification window.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        s         = sinc2_q ^ ACTIVE_LOW;
        cnt_d     = '0;
        estavel_d = estavel_q;
        if (s != estavel_q) begin
            if (cnt_q == CNT_MAX) begin
                estavel_d = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the synchroniser chain
    // depends on this).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sinc1_q   <= NIVEL_SOLTO;
            sinc2_q   <= NIVEL_SOLTO;
            cnt_q     <= '0;
            estavel_q <= 1'b0;
        end else begin
            sinc1_q   <= b_in;
            sinc2_q   <= sinc1_q;
            cnt_q     <= cnt_d;
            estavel_q <= estavel_d;
        end
    end

    assign b_estavel = estavel_q;

endmodule

// File: rtl/classificador_botao.sv
// -----------------------------------------------------------------------------
// classificador_botao
// Conditions one raw pushbutton and classifies each press as short or long.
// Outputs are single-cycle registered pulses, one event per press.
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   b_in         in   raw asynchronous button pin
//   b_estavel    out  debounced level, 1 = pressed
//   pulso_curto  out  one-cycle pulse: short press completed (on release)
//   pulso_longo  out  one-cycle pulse: long-press threshold reached
// Optional build macro BOTAO_REPEAT_EN: while a long press is held, emit an
// extra pulso_longo every REPEAT_CYCLES cycles after the first one.
// -----------------------------------------------------------------------------
module classificador_botao
    import botao_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_PADRAO,
    parameter int unsigned LONG_CYCLES     = LONGO_PADRAO,
    parameter int unsigned REPEAT_CYCLES   = REPETICAO_PADRAO,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic b_in,
    output logic b_estavel,
    output logic pulso_curto,
    output logic pulso_longo
);

    if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES < 2) begin : g_chk_longo
        $error("LONG_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 1) begin : g_chk_repeticao
        $error("REPEAT_CYCLES must be >= 1");
    end

    localparam int unsigned       HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(LONG_CYCLES - 1);

    logic              estavel_q;
    logic              estavel_d;
    estado_t           estado_q;
    estado_t           estado_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              pulso_curto_q;
    logic              pulso_curto_d;
    logic              pulso_longo_q;
    logic              pulso_longo_d;

`ifdef BOTAO_REPEAT_EN
    localparam int unsigned      REP_W   = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] rep_d;
`endif

    debounce_nivel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .b_in      (b_in),
        .b_estavel (estavel_q),
        .estavel_d (estavel_d)
    );

    // The FSM decides on estavel_d (the debounced level of the cycle about to
    // start) so the registered pulse lines up with that cycle: pulso_curto
    // appears in the first cycle b_estavel reads 0. At the edge starting
    // cycle k of a press, hold_q = k - 1.
    always_comb begin
        estado_d      = estado_q;
        hold_d        = hold_q;
        pulso_curto_d = 1'b0;
        pulso_longo_d = 1'b0;
`ifdef BOTAO_REPEAT_EN
        rep_d         = '0;
`endif
        case (estado_q)
            OCIOSO: begin
                hold_d = '0;
                if (estavel_d) begin
                    estado_d = PRESSIONADO;
                end
            end
            PRESSIONADO: begin
                // Threshold wins over release: a press of exactly LONG_CYCLES
                // is long, even though b_estavel is already 0 in that cycle.
                if (hold_q == HOLD_LIM) begin
                    pulso_longo_d = 1'b1;
                    estado_d      = LONGO_EMITIDO;
                end else if (!estavel_d) begin
                    pulso_curto_d = 1'b1;
                    estado_d      = OCIOSO;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            LONGO_EMITIDO: begin
`ifdef BOTAO_REPEAT_EN
                // Repeat point k*REPEAT_CYCLES after the first long pulse,
                // emitted only if the button was still down in the cycle before.
                if (rep_q == REP_MAX) begin
                    pulso_longo_d = estavel_q;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
`endif
                if (!estavel_d) begin
                    estado_d = OCIOSO;
`ifdef BOTAO_REPEAT_EN
                    rep_d    = '0;
`endif
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q      <= OCIOSO;
            hold_q        <= '0;
            pulso_curto_q <= 1'b0;
            pulso_longo_q <= 1'b0;
`ifdef BOTAO_REPEAT_EN
            rep_q         <= '0;
`endif
        end else begin
            estado_q      <= estado_d;
            hold_q        <= hold_d;
            pulso_curto_q <= pulso_curto_d;
            pulso_longo_q <= pulso_longo_d;
`ifdef BOTAO_REPEAT_EN
            rep_q         <= rep_d;
`endif
        end
    end

    assign b_estavel   = estavel_q;
    assign pulso_curto = pulso_curto_q;
    assign pulso_longo = pulso_longo_q;

endmodule

// File: doc/classificador_botao.md
Name: classificador_botao

Overview:
- Front-end conditioning stage for each raw pushbutton; sits directly upstream of the state controller.
- Synchronises and debounces the pin, then classifies each press as short or long.
- Outputs are single-cycle pulses, so the state controller sees exactly one event per press.
- Replaces the plain per-button conditioner in the top level: one instance per button (b1, b2).

Parameters:
- DEBOUNCE_CYCLES, 250000, cycles the synchronised input must hold a new level before it is accepted (10 ms at 25 MHz); must be >= 1.
- LONG_CYCLES, 25000000, cycles the debounced level must stay pressed to count as a long press (1 s); must be >= 2.
- REPEAT_CYCLES, 6250000, interval between repeated long pulses; used only with BOTAO_REPEAT_EN.
- ACTIVE_LOW, 1, 1 = b_in reads 0 when pressed; 0 = b_in reads 1 when pressed.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- b_in  in  1  raw asynchronous button pin
- b_estavel  out  1  debounced level, 1 = pressed (polarity normalised)
- pulso_curto  out  1  one-cycle pulse: short press completed
- pulso_longo  out  1  one-cycle pulse: long-press threshold reached

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n). All state is asynchronously cleared while rst_n = 0.
- Reset values: b_estavel = 0, pulso_curto = 0, pulso_longo = 0.
  - Sync flops reset to the released level.
  - Counters reset to 0; FSM resets to OCIOSO.
- Synchroniser:
  - 2-flop synchroniser on b_in, then polarity normalisation.
  - Normalised value s = 1 when pressed.
- Debounce:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - While s != b_estavel, the counter increments. When it reaches DEBOUNCE_CYCLES-1, b_estavel toggles on that edge and the counter clears.
  - Whenever s == b_estavel, the counter clears, so any glitch shorter than DEBOUNCE_CYCLES is discarded.
  - Latency from b_in edge to b_estavel edge: 2 + DEBOUNCE_CYCLES cycles.
- Timing reference: cycle 0 is the first cycle in which b_estavel reads 1. Let N = number of consecutive cycles b_estavel reads 1.
- FSM states:
  - OCIOSO
    - b_estavel rises -> PRESSIONADO; hold counter cleared.
  - PRESSIONADO
    - Hold counter increments each cycle.
    - If N reaches LONG_CYCLES: pulso_longo = 1 at cycle LONG_CYCLES, then -> LONGO_EMITIDO.
    - If b_estavel falls first (N < LONG_CYCLES): pulso_curto = 1 at cycle N (first cycle b_estavel reads 0), then -> OCIOSO.
  - LONGO_EMITIDO
    - b_estavel low -> OCIOSO. No release pulse.
- Boundary: N == LONG_CYCLES exactly -> long only. pulso_longo fires at cycle LONG_CYCLES, coinciding with b_estavel = 0; pulso_curto is never asserted.
- Pulse rules:
  - pulso_curto and pulso_longo are never high in the same cycle.
  - Each pulse is exactly one cycle wide.
  - Both are registered outputs.
- Hold counter: width $clog2(LONG_CYCLES+1); saturates and never wraps.
- Reset mid-press: outputs drop immediately. After release, if the button is still held at reset deassertion, it is treated as a fresh press once debounce completes.

Optional Feature:
- Macro: BOTAO_REPEAT_EN.
- Defined: in LONGO_EMITIDO, a repeat counter emits an extra one-cycle pulso_longo at cycles LONG_CYCLES + k*REPEAT_CYCLES (k >= 1) while b_estavel is still 1 in the preceding cycle. The repeat counter clears on exit from LONGO_EMITIDO.
- Undefined: exactly one pulso_longo per press; no repeat counter is synthesised.

Decomposition:
- Package botao_pkg:
  - FSM state typedef (OCIOSO, PRESSIONADO, LONGO_EMITIDO).
  - Default constants DEBOUNCE_PADRAO, LONGO_PADRAO, REPETICAO_PADRAO.
- Sub-module debounce_nivel: synchroniser, polarity normalisation and debounce counter; outputs b_estavel.
- The classifier FSM stays in the top of the block.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=0.
- Glitch: b_in high for 3 cycles -> b_estavel stays 0; no pulses.
- Short press: b_in high for 10 cycles -> b_estavel rises 6 cycles after the b_in edge and stays high 10 cycles; pulso_curto one cycle at N=10; no pulso_longo.
- Threshold boundary:
  - N=19 -> pulso_curto only.
  - N=20 -> pulso_longo at cycle 20; no pulso_curto.
- Long hold of 40 debounced cycles -> single pulso_longo at cycle 20; release gives no pulse. With BOTAO_REPEAT_EN: pulso_longo at cycles 20, 28 and 36.
- Reset mid-hold: rst_n=0 at cycle 12 for 2 cycles while pressed -> all outputs 0 immediately; button held through reset -> b_estavel re-rises 6 cycles after rst_n release. Release before LONG_CYCLES -> one pulso_curto.
